// File: rtl/psum_acc.sv
// Accumulates signed partial-sum beats into a saturating group total and emits one result per group.
// Latency: result valid one cycle after the last beat; in_ready = !out_valid || out_ready (stalls while a result waits).
module psum_acc #(
    parameter int bw_psum = 22,
    parameter int bw_acc  = 26,
    parameter int cnt_bw  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [bw_psum-1:0] in,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    input  logic                      relu_en,
    output logic signed [bw_acc-1:0]  out,
    output logic [cnt_bw-1:0]         out_cnt,
    output logic                      out_sat,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        PART  = 1'b1
    } state_t;

    localparam logic signed [bw_acc-1:0] ACC_MAX = {1'b0, {(bw_acc-1){1'b1}}};
    localparam logic signed [bw_acc-1:0] ACC_MIN = {1'b1, {(bw_acc-1){1'b0}}};
    localparam logic [cnt_bw-1:0]        CNT_MAX = {cnt_bw{1'b1}};
    localparam logic [cnt_bw-1:0]        CNT_ONE = cnt_bw'(1);

    state_t                    state_q, state_d;
    logic signed [bw_acc-1:0]  acc_q, acc_d;
    logic [cnt_bw-1:0]         cnt_q, cnt_d;
    logic                      sat_q, sat_d;
    logic signed [bw_acc-1:0]  out_q, out_d;
    logic [cnt_bw-1:0]         out_cnt_q, out_cnt_d;
    logic                      out_sat_q, out_sat_d;
    logic                      out_valid_q, out_valid_d;

    logic                      accept;
    logic                      xfer;
    logic signed [bw_acc-1:0]  in_ext;
    logic signed [bw_acc:0]    sum_wide;
    logic                      ovf;
    logic signed [bw_acc-1:0]  sum_sat;
    logic signed [bw_acc-1:0]  beat_sum;
    logic [cnt_bw-1:0]         beat_cnt;
    logic                      beat_sat;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    assign in_ext   = {{(bw_acc-bw_psum){in[bw_psum-1]}}, in};

    // One guard bit: overflow shows up as the two top bits disagreeing.
    assign sum_wide = {acc_q[bw_acc-1], acc_q} + {in_ext[bw_acc-1], in_ext};
    assign ovf      = sum_wide[bw_acc] ^ sum_wide[bw_acc-1];
    assign sum_sat  = ovf ? (sum_wide[bw_acc] ? ACC_MIN : ACC_MAX) : sum_wide[bw_acc-1:0];

    always_comb begin
        beat_sum = in_ext;
        beat_cnt = CNT_ONE;
        beat_sat = 1'b0;
        if (state_q == PART) begin
            beat_sum = sum_sat;
            beat_cnt = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
            beat_sat = sat_q | ovf;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_d       = out_q;
        out_cnt_d   = out_cnt_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;

        if (accept && in_last) begin
            state_d     = EMPTY;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            out_d       = (relu_en && beat_sum[bw_acc-1]) ? '0 : beat_sum;
            out_cnt_d   = beat_cnt;
            out_sat_d   = beat_sat;
            out_valid_d = 1'b1;
        end else begin
            if (accept) begin
                state_d = PART;
                acc_d   = beat_sum;
                cnt_d   = beat_cnt;
                sat_d   = beat_sat;
            end
            // Result register keeps its value after hand-off; only the valid drops.
            if (xfer) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_q       <= '0;
            out_cnt_q   <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_q       <= out_d;
            out_cnt_q   <= out_cnt_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_cnt   = out_cnt_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/psum_acc.md
PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001 SHALL have parameter bw_psum, default 22: width of each signed partial sum from the 8-lane MAC stage.
REQ-002 SHALL have parameter bw_acc, default 26: width of the signed accumulator and the result.
REQ-003 SHALL have parameter cnt_bw, default 5: width of the beat counter.
REQ-004 SHALL use one clock, clk; reset is asynchronous and active-high, named reset.
REQ-005 port: clk  input  1  rising-edge clock.
REQ-006 port: reset  input  1  asynchronous active-high reset.
REQ-007 port: in  input  bw_psum  signed partial sum (MAC output).
REQ-008 port: in_valid  input  1  in is valid this cycle.
REQ-009 port: in_last  input  1  qualifies the final beat of a group; sampled only on accept.
REQ-010 port: in_ready  output  1  block accepts a beat this cycle.
REQ-011 port: relu_en  input  1  apply ReLU to the result; sampled with the last beat.
REQ-012 port: out  output  bw_acc  signed accumulated result.
REQ-013 port: out_cnt  output  cnt_bw  number of beats in the group that produced out.
REQ-014 port: out_sat  output  1  saturation occurred anywhere within the group.
REQ-015 port: out_valid  output  1  out, out_cnt and out_sat are valid.
REQ-016 port: out_ready  input  1  consumer takes the result.

Function
REQ-017 Accept occurs when in_valid && in_ready; transfer occurs when out_valid && out_ready.
REQ-018 in_ready SHALL be combinational: !out_valid || out_ready. It SHALL NOT depend on in_valid.
REQ-019 Each accepted in SHALL be sign-extended to bw_acc.
REQ-020 Accept on the first beat of a group (state EMPTY): acc <= sext(in), cnt <= 1, sat <= 0.
REQ-021 Accept otherwise (state PART): acc <= acc + sext(in), computed at bw_acc+1 bits.
REQ-022 On overflow, REQ-021 SHALL clamp acc to +2^(bw_acc-1)-1 or -2^(bw_acc-1) and set sat.
REQ-023 On a non-first accept, cnt SHALL increment and saturate at 2^cnt_bw-1.
REQ-024 State machine: EMPTY -> PART on accept without in_last.
REQ-025 State machine: PART -> PART on accept without in_last.
REQ-026 State machine: EMPTY or PART -> EMPTY on accept with in_last.
REQ-027 On a last-beat accept at edge t, the final sum (including that beat, saturated) SHALL be loaded into the output register at edge t.
REQ-028 The loaded value SHALL be 0 if relu_en is 1 and the sum is negative; out_cnt and out_sat SHALL be loaded with it, and out_valid SHALL be high from t+1. Latency from last beat to result is one cycle.
REQ-029 A single beat with in_last in EMPTY SHALL produce out = sext(in) (ReLU applied if enabled) and out_cnt = 1.
REQ-030 Transfer without a simultaneous last accept SHALL clear out_valid at the next edge; out SHALL hold its last value.
REQ-031 Transfer and last accept in the same cycle SHALL load the new result and keep out_valid = 1, with no bubble.
REQ-032 While out_valid && !out_ready, out, out_cnt and out_sat SHALL be stable and in_ready SHALL be 0.
REQ-033 Beats with in_valid = 0 SHALL leave all state unchanged, and gaps within a group are allowed.

Reset
REQ-034 Reset asserted SHALL immediately force: acc = 0, cnt = 0, sat = 0, state EMPTY, out = 0, out_cnt = 0, out_sat = 0, out_valid = 0.
REQ-035 After reset, in_ready SHALL be 1.
REQ-036 A reset mid-group SHALL discard the partial sum. The first accept after deassertion is a first beat.

Verification
REQ-037 in = 100, -30, 5 (last on 5), relu_en = 0, out_ready = 1 -> one cycle after the last beat: out = 75, out_cnt = 3, out_sat = 0, out_valid for 1 cycle.
REQ-038 in = -50, 20 (last), relu_en = 1 -> out = 0, out_cnt = 2; the same group with relu_en = 0 -> out = -30.
REQ-039 Drive 40 beats of +2^21-1 (bw_acc = 26), last on beat 40 -> out = 2^25-1, out_sat = 1, out_cnt = 31.
REQ-040 Back-to-back single-beat groups 7, 8, 9 with out_ready held 1 -> out_valid continuously high, out = 7, 8, 9 on consecutive cycles.
REQ-041 Result 12 pending with out_ready = 0 for 5 cycles -> in_ready = 0 and out stable at 12; out_ready = 1 -> transfer, in_ready = 1 in the same cycle.
REQ-042 Reset pulsed after beats 10 and 20 -> all outputs 0; the next group of 3 with last -> out = 3, out_cnt = 1.
